// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and width helper for the UART receive path.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data, count, full and empty.
// Latency: push visible in count/empty next edge; pop data valid one cycle after rd_en.
// Backpressure: writes to a full FIFO are dropped unless a pop happens on the same edge.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           rd_valid,
  output logic                           full,
  output logic                           empty,
  output logic [count_width(DEPTH)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_nxt, rd_nxt;
  logic             rd_ok, wr_ok;

  assign rd_ok  = rd_en && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
  assign wr_ok  = wr_en && (!full || rd_ok);
  assign wr_nxt = wr_ptr + {{AW{1'b0}}, wr_ok};
  assign rd_nxt = rd_ptr + {{AW{1'b0}}, rd_ok};

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
      count    <= '0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
      full  <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty <= (wr_nxt == rd_nxt);
      count <= CW'(wr_nxt - rd_nxt);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (majority-voted bits, parity/framing/overrun flags) feeding a receive FIFO.
// Latency: word pushed the cycle after the stop-bit vote; pop data one cycle after rd_en.
// Backpressure: none on rx; good frames arriving while full are dropped with overrun. Option: UART_RX_ERR_CNT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PAR_EVEN,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                rx,
  input  logic                                rd_en,
  output logic [DATA_BITS-1:0]                rd_data,
  output logic                                rd_perr,
  output logic                                rd_valid,
  output logic                                empty,
  output logic                                full,
  output logic [count_width(FIFO_DEPTH)-1:0]  count,
  output logic                                frame_err,
  output logic                                overrun,
  output logic                                heard_bit_out
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]                          perr_cnt,
  output logic [7:0]                          ferr_cnt,
  output logic [7:0]                          ovr_cnt
`endif
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  rx_state_t            state, state_nxt;
  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 samp0, samp1;
  logic                 vote;
  logic                 mid_vote, cell_end;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 stop_ok, stop_bad;
  logic                 push_acc;
  logic [DATA_BITS:0]   fifo_rd_data;

  assign rx_s     = rx_sync[1];
  assign mid_vote = (clk_cnt == CW'(HALF + 1));
  assign cell_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign vote     = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign push_acc = stop_ok && (!full || (rd_en && !empty));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (mid_vote && vote) state_nxt = ST_IDLE;
        else if (cell_end)    state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (cell_end && bit_cnt == BW'(DATA_BITS - 1))
          state_nxt = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (cell_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Leave at the mid-bit vote so a following start bit is never missed.
        if (mid_vote) begin
          state_nxt = ST_IDLE;
          stop_ok   = vote;
          stop_bad  = !vote;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync       <= 2'b11;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      samp0         <= 1'b1;
      samp1         <= 1'b1;
      shreg         <= '0;
      perr          <= 1'b0;
      heard_bit_out <= 1'b1;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};

      if (state == ST_IDLE || state_nxt != state || cell_end) clk_cnt <= '0;
      else                                                    clk_cnt <= clk_cnt + 1'b1;

      if (state == ST_IDLE)                  bit_cnt <= '0;
      else if (state == ST_DATA && cell_end) bit_cnt <= bit_cnt + 1'b1;

      if (clk_cnt == CW'(HALF - 1)) samp0 <= rx_s;
      if (clk_cnt == CW'(HALF))     samp1 <= rx_s;

      if (state != ST_IDLE && mid_vote) heard_bit_out <= vote;

      if (state == ST_DATA && mid_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};

      if (state == ST_IDLE)
        perr <= 1'b0;
      else if (state == ST_PARITY && mid_vote)
        perr <= vote ^ (^shreg) ^ (PARITY_MODE == PAR_ODD);

      frame_err <= stop_bad;
      overrun   <= stop_ok && full && !rd_en;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (stop_ok),
    .wr_data  ({perr, shreg}),
    .rd_en    (rd_en),
    .rd_data  (fifo_rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign rd_data = fifo_rd_data[DATA_BITS-1:0];
  assign rd_perr = fifo_rd_data[DATA_BITS];

`ifdef UART_RX_ERR_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perr_cnt <= '0;
      ferr_cnt <= '0;
      ovr_cnt  <= '0;
    end else begin
      if (push_acc && perr && perr_cnt != 8'hFF)          perr_cnt <= perr_cnt + 1'b1;
      if (stop_bad && ferr_cnt != 8'hFF)                  ferr_cnt <= ferr_cnt + 1'b1;
      if (stop_ok && full && !rd_en && ovr_cnt != 8'hFF)  ovr_cnt  <= ovr_cnt + 1'b1;
    end
  end
`else
  logic unused_push_acc;
  assign unused_push_acc = push_acc;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table of frames plus hand sequences for glitch, overrun and mid-frame reset.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;
  logic       heard_bit_out;

  int n_vec = 0;
  int n_err = 0;
  int ferr_seen = 0;
  int ovr_seen  = 0;
  int m_count   = 0;
  int f0, o0;
  logic [8:0] sb_q[$];

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic       do_pop;
    int         exp_count;
    int         exp_ferr;
  } vec_t;

  vec_t vt[7];

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .PARITY_MODE  (1),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_perr       (rd_perr),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .heard_bit_out (heard_bit_out)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_err) ferr_seen++;
    if (overrun)   ovr_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ bad_par);
    send_bit(stop);
    rx = 1'b1;
    if (stop && m_count < DEPTH) begin
      sb_q.push_back({bad_par, d});
      m_count++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] exp;
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    check({tag, " rd_valid"}, rd_valid, 1);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard"}, 0, 1);
    end else begin
      exp = sb_q.pop_front();
      m_count--;
      check({tag, " rd_data"}, rd_data, exp[7:0]);
      check({tag, " rd_perr"}, rd_perr, exp[8]);
    end
    @(negedge clock);
    check({tag, " rd_valid pulse"}, rd_valid, 0);
    check({tag, " count after pop"}, count, m_count);
  endtask

  initial begin
    vt[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1, 0};
    vt[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1, 0};
    vt[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 0, 1};
    vt[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1, 0};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1, 0};
    vt[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 2, 0};
    vt[6] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1, 1};

    reset = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clock);
    check("reset rd_data", rd_data, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset empty", empty, 1);
    check("reset full", full, 0);
    check("reset count", count, 0);
    check("reset heard_bit", heard_bit_out, 1);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      f0 = ferr_seen;
      o0 = ovr_seen;
      send_frame(vt[i].data, vt[i].bad_par, vt[i].stop);
      repeat (4) @(negedge clock);
      check($sformatf("v%0d count", i), count, vt[i].exp_count);
      check($sformatf("v%0d empty", i), empty, (vt[i].exp_count == 0));
      check($sformatf("v%0d frame_err", i), ferr_seen - f0, vt[i].exp_ferr);
      check($sformatf("v%0d overrun", i), ovr_seen - o0, 0);
      if (vt[i].do_pop) pop_check($sformatf("v%0d pop", i));
    end

    // Short low glitch must be rejected in START.
    f0 = ferr_seen;
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch count", count, 0);
    check("glitch frame_err", ferr_seen - f0, 0);
    check("glitch heard_bit", heard_bit_out, 1);
    send_frame(8'h96, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    check("post-glitch count", count, 1);
    pop_check("post-glitch pop");

    // Back-to-back frames into a 4-deep FIFO.
    f0 = ferr_seen;
    o0 = ovr_seen;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b0, 1'b1);
      if (k == 3) check("b2b full after 3", full, 0);
      if (k == 4) check("b2b full after 4", full, 1);
      if (k == 4) check("b2b overrun before 5th", ovr_seen - o0, 0);
    end
    repeat (4) @(negedge clock);
    check("b2b overrun", ovr_seen - o0, 1);
    check("b2b count", count, 4);
    check("b2b full", full, 1);
    check("b2b frame_err", ferr_seen - f0, 0);
    for (int k = 1; k <= 4; k++) pop_check($sformatf("b2b pop %0d", k));
    check("b2b empty", empty, 1);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    @(negedge clock);
    check("pop on empty", rd_valid, 0);
    check("pop on empty count", count, 0);

    // Mid-frame reset with a word already buffered.
    send_frame(8'h11, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    check("pre-reset count", count, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (14) @(negedge clock);
    check("pre-reset heard_bit", heard_bit_out, 0);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clock);
    sb_q.delete();
    m_count = 0;
    check("mid reset rd_data", rd_data, 0);
    check("mid reset rd_perr", rd_perr, 0);
    check("mid reset rd_valid", rd_valid, 0);
    check("mid reset empty", empty, 1);
    check("mid reset full", full, 0);
    check("mid reset count", count, 0);
    check("mid reset frame_err", frame_err, 0);
    check("mid reset overrun", overrun, 0);
    check("mid reset heard_bit", heard_bit_out, 1);
    reset = 1'b0;
    repeat (CPB * 2) @(negedge clock);
    check("post reset count", count, 0);
    send_frame(8'hC3, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    check("C3 count", count, 1);
    pop_check("C3 pop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a receive FIFO: the next-generation receive path for the MIPS_UART design. Deserialises the `rx` line at a configurable bit period, data width and parity mode, majority-votes each bit, flags parity/framing/overrun errors, and buffers received words for the CPU-side reader. It replaces the fixed 9-bit receive shift-register path and sits between the board `rx` pin and the MIPS I/O read logic.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per bit period (50 MHz / 9600 baud); minimum 8.
- `DATA_BITS`, 8: data bits per frame, 5–9, sent LSB first.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `FIFO_DEPTH`, 16: receive FIFO entries; power of two, at least 2.

- `clock` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input; idle high.
- `rd_en` in 1: pop request; ignored when `empty`.
- `rd_data` out DATA_BITS: popped word.
- `rd_perr` out 1: parity-error flag stored with the popped word.
- `rd_valid` out 1: one-cycle pulse; `rd_data`/`rd_perr` valid.
- `empty` out 1: FIFO holds no words.
- `full` out 1: FIFO holds FIFO_DEPTH words.
- `count` out clog2(FIFO_DEPTH+1): current occupancy.
- `frame_err` out 1: one-cycle pulse; stop bit sampled low.
- `overrun` out 1: one-cycle pulse; a good frame was dropped because the FIFO was full.
- `heard_bit_out` out 1: most recent majority-voted bit (debug).

## Operation
- `rx` is passed through a two-flop synchroniser. The synchroniser resets to 1.
- Bit value = majority of three samples, taken at `CLKS_PER_BIT/2-1`, `/2` and `/2+1` of the bit cell.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when the synchronised `rx` is 0. The bit counter clears.
  - START: at the mid-bit vote, 1 → IDLE (glitch rejected); 0 → DATA at the end of the cell.
  - DATA: vote at mid-cell and shift in LSB first. After DATA_BITS bits, go to PARITY if `PARITY_MODE≠0`, else STOP.
  - PARITY: vote and compare against the XOR of the data bits (even or odd). The mismatch is latched as the word's `perr`.
  - STOP: at the mid-bit vote, go to IDLE immediately, not at the end of the cell. This allows a back-to-back start within half a bit.
- Stop bit = 1: push `{perr, data}` into the FIFO. If `full`, drop the word and pulse `overrun`.
- Stop bit = 0: pulse `frame_err`, discard the word, no push.
- Pop: `rd_en && !empty` → the next cycle drives `rd_data`/`rd_perr` from the head and pulses `rd_valid`. `rd_data` holds until the next pop.
- Simultaneous push and pop:
  - When full: both are performed, no overrun, `count` is unchanged.
  - When empty: the pop is ignored and the push happens.
- Reset (including mid-frame) drives these values:
  - FSM in IDLE; all counters at 0; FIFO empty.
  - `rd_data`=0, `rd_perr`=0, `rd_valid`=0.
  - `empty`=1, `full`=0, `count`=0.
  - `frame_err`=0, `overrun`=0, `heard_bit_out`=1.
  - A partial frame is discarded.

## Timing
- Synchroniser delay: 2 cycles.
- Push occurs on the cycle after the stop-bit majority decision. `empty` falls and `count` increments that same edge.
- Pop latency: 1 cycle from `rd_en` to `rd_valid`.
- `empty`, `full` and `count` update on the edge that performs the push or pop. All outputs are registered.
- Error pulses are exactly one cycle wide and coincide with the cycle the push would have occurred.

## Configuration
- `UART_RX_ERR_CNT_EN` defined adds three 8-bit saturating counters: parity, frame and overrun. They are exposed on extra ports `perr_cnt`, `ferr_cnt` and `ovr_cnt`, and cleared by `reset`.
  - The counters increment on the corresponding event and stick at 255.
  - The parity counter increments on push of a word with `perr=1`.
- Without the macro, the counters and ports do not exist, and all other behaviour is identical.

## Structure
- Shared package `uart_pkg` holds:
  - parity-mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - the FSM state encoding;
  - a `clog2`-based width helper for `count`.
- One sub-module, `uart_sync_fifo`: synchronous FIFO of width DATA_BITS+1 and depth FIFO_DEPTH. It provides registered read data, count, full and empty, and wrap-around pointers with one extra bit. The FSM, synchroniser and majority vote stay in `uart_rx_fifo`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, `DATA_BITS`=8, `PARITY_MODE`=1, `FIFO_DEPTH`=4.
- Send 0xA5 with even parity 0 and stop 1 → `count`=1, `empty`=0. Then `rd_en` → `rd_valid` with `rd_data`=0xA5 and `rd_perr`=0.
- Send 0x3C with parity bit 1 (wrong) → word pushed. Pop gives `rd_data`=0x3C and `rd_perr`=1.
- Send 0x55 with stop bit 0 → `frame_err` pulses once, `count` stays 0.
- Pulse `rx` low for 4 cycles, then high → FSM returns to IDLE, no push, no `frame_err`.
- Send 0x01–0x05 back-to-back with no reads → `full` after the 4th, `overrun` pulses on the 5th. Four pops return 0x01–0x04 in order, then `empty`=1.
- Assert `reset` during the 4th data bit of a frame → all outputs at reset values. The next frame, 0xC3, is received correctly.
